// File: rtl/sign_mag_decoder.sv
// sign_mag_decoder: two's-complement to sign/magnitude converter, resolved serially.
// Latency: operand accepted at edge E0, result held with out_valid=1 after edge E0+N,
//          N = 32/STEP_BITS (8 at the default), the same for every operand and build.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready=1.
//
// Parameters
//   STEP_BITS  bits of magnitude resolved per cycle (1, 2, 4, 8, 16 or 32)
// Build option
//   SIGN_MAG_SATURATE_EN  when defined, operand 0x80000000 gives out_mag = 0x7FFFFFFF
//                         instead of the wrapped 0x80000000 (out_ovf = 1 in both builds)
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data holds an operand
//   in_ready   block accepts an operand (IDLE only)
//   in_data    32-bit two's-complement operand
//   out_valid  result available (DONE only)
//   out_ready  consumer takes the result; ignored outside DONE
//   out_sign   1 = operand was negative
//   out_mag    32-bit unsigned magnitude, modulo 2^32
//   out_ovf    operand was 0x80000000
module sign_mag_decoder #(
  parameter int STEP_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [31:0] out_mag,
  output logic        out_ovf
);

  localparam int N  = 32 / STEP_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     opnd_q,  opnd_d;
  logic [31:0]     mag_q,   mag_d;
  logic            sign_q,  sign_d;
  logic            ovf_q,   ovf_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   count_q, count_d;

  logic                 accept;
  logic                 take;
  logic                 last_step;
  logic [STEP_BITS-1:0] chunk;
  logic [STEP_BITS:0]   neg_sum;
  logic [STEP_BITS-1:0] res;
  logic [31:0]          res_ext;
  logic [31:0]          mag_shift;

  assign accept    = in_valid && (state_q == IDLE);
  assign take      = out_ready && (state_q == DONE);
  assign last_step = (state_q == BUSY) && (count_q == LAST_CNT);

  // The operand is shifted right one chunk per cycle, so the chunk being
  // resolved (chunk[count], LSB first) always sits in the low bits.
  assign chunk   = opnd_q[STEP_BITS-1:0];

  // Negation chunk by chunk: invert and add the carry rippled from the
  // previous (lower) chunk. The extra top bit is the carry-out.
  assign neg_sum = {1'b0, ~chunk} + {{STEP_BITS{1'b0}}, carry_q};
  assign res     = sign_q ? neg_sum[STEP_BITS-1:0] : chunk;

  // Resolved chunks enter at the top of mag and move down one chunk per
  // cycle; after N steps chunk 0 has reached bit 0.
  assign res_ext   = 32'(res);
  assign mag_shift = (mag_q >> STEP_BITS) | (res_ext << (32 - STEP_BITS));

  // ---------------------------------------------------------------------------
  // State register (FSM state plus datapath registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)    state_d = BUSY;
      BUSY: if (last_step) state_d = DONE;
      // Leaving DONE always goes through IDLE, so no accept can overlap
      // the cycle in which the result is taken.
      DONE: if (take)      state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    opnd_d  = opnd_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
    count_d = count_q;

    if (accept) begin
      opnd_d  = in_data;
      mag_d   = '0;
      sign_d  = in_data[31];
      ovf_d   = (in_data == 32'h8000_0000);
      carry_d = 1'b1;
      count_d = '0;
    end else if (state_q == BUSY) begin
      opnd_d  = opnd_q >> STEP_BITS;
      mag_d   = mag_shift;
      // The carry is only meaningful for negative operands; the final
      // carry-out is simply left in carry_q and never used.
      carry_d = sign_q ? neg_sum[STEP_BITS] : carry_q;
      count_d = last_step ? '0 : count_q + CW'(1);
`ifdef SIGN_MAG_SATURATE_EN
      // Clamp on the last step so latency matches the wrapping build.
      if (last_step && ovf_q) mag_d = 32'h7FFF_FFFF;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_sign  = sign_q;
    out_mag   = mag_q;
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_sign_mag_decoder.sv
// Directed bench for sign_mag_decoder: default STEP_BITS=4 instance plus
// STEP_BITS=1 and STEP_BITS=32 instances sharing the same input drive.
module tb_sign_mag_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;

  logic        in_ready,  out_valid,  out_sign,  out_ovf;
  logic [31:0] out_mag;
  logic        in_ready1, out_valid1, out_sign1, out_ovf1;
  logic [31:0] out_mag1;
  logic        in_ready32, out_valid32, out_sign32, out_ovf32;
  logic [31:0] out_mag32;

  int checks = 0;
  int errors = 0;

`ifdef SIGN_MAG_SATURATE_EN
  localparam logic [31:0] OVF_MAG = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OVF_MAG = 32'h8000_0000;
`endif

  always #5 clk = ~clk;

  sign_mag_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_mag(out_mag), .out_ovf(out_ovf));

  sign_mag_decoder #(.STEP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sign(out_sign1),
    .out_mag(out_mag1), .out_ovf(out_ovf1));

  sign_mag_decoder #(.STEP_BITS(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_data(in_data),
    .out_valid(out_valid32), .out_ready(out_ready), .out_sign(out_sign32),
    .out_mag(out_mag32), .out_ovf(out_ovf32));

  // Advance one rising edge and settle before sampling / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand for exactly one edge (block assumed IDLE).
  task automatic accept_op(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // Edges after acceptance until out_valid rises; -1 if it never does.
  task automatic wait_done(output int edges);
    int i;
    i = 0;
    edges = -1;
    while (edges < 0 && i < 100) begin
      step();
      i++;
      if (out_valid === 1'b1) edges = i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if ({out_sign, out_ovf, out_mag} !== 34'h0)
      begin errors++; $display("FAIL reset_outputs got sign %b ovf %b mag %h exp all 0", out_sign, out_ovf, out_mag); end
    // Reset wins over a simultaneous handshake.
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFB;
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_sign !== 1'b0)
      begin errors++; $display("FAIL reset_priority got in_ready %b sign %b exp 1 0", in_ready, out_sign); end
    step();
    checks++; if (in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_priority_idle got in_ready %b exp 1", in_ready); end
  endtask

  task automatic test_positive();
    int e;
    out_ready = 1'b1;
    accept_op(32'h0000_0005);
    wait_done(e);
    checks++; if (e !== 8) begin errors++; $display("FAIL pos_latency got %0d exp 8", e); end
    checks++; if ({out_sign, out_ovf, out_mag} !== {2'b00, 32'h0000_0005})
      begin errors++; $display("FAIL pos_result got sign %b ovf %b mag %h exp 0 0 00000005", out_sign, out_ovf, out_mag); end
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL pos_release got in_ready %b out_valid %b exp 1 0", in_ready, out_valid); end
  endtask

  task automatic test_negative();
    int e;
    out_ready = 1'b1;
    accept_op(32'hFFFF_FFFB);
    wait_done(e);
    checks++; if (e !== 8) begin errors++; $display("FAIL neg5_latency got %0d exp 8", e); end
    checks++; if ({out_sign, out_ovf, out_mag} !== {2'b10, 32'h0000_0005})
      begin errors++; $display("FAIL neg5_result got sign %b ovf %b mag %h exp 1 0 00000005", out_sign, out_ovf, out_mag); end
    step();
    accept_op(32'hFFFF_FFFF);
    wait_done(e);
    checks++; if ({out_sign, out_ovf, out_mag} !== {2'b10, 32'h0000_0001})
      begin errors++; $display("FAIL neg1_result got sign %b ovf %b mag %h exp 1 0 00000001", out_sign, out_ovf, out_mag); end
    step();
    accept_op(32'hFFFF_0000);
    wait_done(e);
    checks++; if (out_mag !== 32'h0001_0000)
      begin errors++; $display("FAIL negffff0000_mag got %h exp 00010000", out_mag); end
    step();
  endtask

  task automatic test_overflow();
    int e;
    out_ready = 1'b1;
    accept_op(32'h8000_0000);
    wait_done(e);
    checks++; if (e !== 8) begin errors++; $display("FAIL ovf_latency got %0d exp 8", e); end
    checks++; if ({out_sign, out_ovf, out_mag} !== {2'b11, OVF_MAG})
      begin errors++; $display("FAIL ovf_result got sign %b ovf %b mag %h exp 1 1 %h", out_sign, out_ovf, out_mag, OVF_MAG); end
    step();
  endtask

  task automatic test_backpressure();
    int e;
    out_ready = 1'b0;
    accept_op(32'hFFFF_FFF0);
    wait_done(e);
    checks++; if (e !== 8) begin errors++; $display("FAIL hold_latency got %0d exp 8", e); end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 32'h1234_5678;
      step();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== 1'b1 || out_mag !== 32'h0000_0010)
        begin errors++; $display("FAIL hold_cycle%0d got valid %b ready %b sign %b mag %h exp 1 0 1 00000010", i, out_valid, in_ready, out_sign, out_mag); end
    end
    // Release with the next operand already waiting: no accept on the exit edge.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b1)
      begin errors++; $display("FAIL hold_exit got ready %b valid %b sign %b exp 1 0 1", in_ready, out_valid, out_sign); end
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_second_accept got in_ready %b exp 0", in_ready); end
    wait_done(e);
    checks++; if (e !== 8 || {out_sign, out_ovf, out_mag} !== {2'b00, 32'h1234_5678})
      begin errors++; $display("FAIL hold_second_result got edges %0d sign %b ovf %b mag %h exp 8 0 0 12345678", e, out_sign, out_ovf, out_mag); end
    step();
  endtask

  task automatic test_reset_busy();
    int e;
    out_ready = 1'b1;
    accept_op(32'hFFFF_FFF9);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mag !== 32'h0 || out_sign !== 1'b0)
      begin errors++; $display("FAIL busy_reset got ready %b valid %b sign %b mag %h exp 1 0 0 00000000", in_ready, out_valid, out_sign, out_mag); end
    accept_op(32'h0000_0000);
    wait_done(e);
    checks++; if (e !== 8 || {out_sign, out_ovf, out_mag} !== 34'h0)
      begin errors++; $display("FAIL zero_result got edges %0d sign %b ovf %b mag %h exp 8 0 0 00000000", e, out_sign, out_ovf, out_mag); end
    step();
  endtask

  task automatic test_step_variants();
    int e4, e1, e32;
    logic [31:0] m4, m1, m32;
    e4 = -1; e1 = -1; e32 = -1; m4 = '0; m1 = '0; m32 = '0;
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    accept_op(32'hFFFF_0000);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (e4  < 0 && out_valid   === 1'b1) begin e4  = i; m4  = out_mag;   end
      if (e1  < 0 && out_valid1  === 1'b1) begin e1  = i; m1  = out_mag1;  end
      if (e32 < 0 && out_valid32 === 1'b1) begin e32 = i; m32 = out_mag32; end
    end
    checks++; if (e4 !== 8 || m4 !== 32'h0001_0000)
      begin errors++; $display("FAIL step4 got edges %0d mag %h exp 8 00010000", e4, m4); end
    checks++; if (e1 !== 32 || m1 !== 32'h0001_0000)
      begin errors++; $display("FAIL step1 got edges %0d mag %h exp 32 00010000", e1, m1); end
    checks++; if (e32 !== 1 || m32 !== 32'h0001_0000)
      begin errors++; $display("FAIL step32 got edges %0d mag %h exp 1 00010000", e32, m32); end
    checks++; if (out_valid32 !== 1'b1 || out_mag32 !== 32'h0001_0000 || out_sign32 !== 1'b1)
      begin errors++; $display("FAIL step32_hold got valid %b mag %h sign %b exp 1 00010000 1", out_valid32, out_mag32, out_sign32); end
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_positive();
    test_negative();
    test_overflow();
    test_backpressure();
    test_reset_busy();
    test_step_variants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
